// File: rtl/datapath_controller_if.sv
// Bus between the instruction source / datapath and the sequencing controller.
// The controller sits on the slave side; the source/datapath side is master.
interface datapath_controller_if #(
    parameter int IW = 16
);
    // Instruction source handshake
    logic [IW-1:0] in;
    logic          load;
    logic          s;
    logic          w;
    logic          done;
    logic          err;

    // Datapath control word
    logic [IW-1:0] datapath_in;
    logic [2:0]    writenum;
    logic [2:0]    readnum;
    logic          write;
    logic          vsel;
    logic          asel;
    logic          bsel;
    logic          loada;
    logic          loadb;
    logic          loadc;
    logic          loads;
    logic [1:0]    ALUop;
    logic [1:0]    shift;

    modport master (
        output in, load, s,
        input  w, done, err, datapath_in, writenum, readnum, write,
               vsel, asel, bsel, loada, loadb, loadc, loads, ALUop, shift
    );

    modport slave (
        input  in, load, s,
        output w, done, err, datapath_in, writenum, readnum, write,
               vsel, asel, bsel, loada, loadb, loadc, loads, ALUop, shift
    );
endinterface

// File: rtl/datapath_controller.sv
// Sequencing FSM for the 16-bit register/ALU/shifter datapath.
// Captures an instruction in WAIT, decodes it and issues one Moore control
// word per cycle until write-back, then returns to WAIT.
module datapath_controller #(
    parameter int IW = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    datapath_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        DECODE    = 3'd1,
        WRITE_IMM = 3'd2,
        GET_A     = 3'd3,
        GET_B     = 3'd4,
        ALU       = 3'd5,
        WRITE_REG = 3'd6
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [IW-1:0] ir;
    logic          err_q;

    // Instruction fields
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;
    logic [4:0] opkey;
    logic       illegal;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];
    assign opkey  = {opcode, op};

    // The only encodings this controller executes; everything else flags err.
    assign illegal = !(opkey == 5'b110_10 || opkey == 5'b110_00 ||
                       opcode == 3'b101);

    // Immediate is always presented, sign-extended from imm8.
    assign bus.datapath_in = {{(IW-8){ir[7]}}, ir[7:0]};
    assign bus.err         = err_q;

    // State register with synchronous active-low reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Instruction register (loads only in WAIT) and sticky illegal-opcode flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ir    <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == WAIT && bus.load) begin
                ir <= bus.in;
            end
            if (state == DECODE && illegal) begin
                err_q <= 1'b1;
            end
        end
    end

    // Next-state decode.
    // NOTE: default assignment first, so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            WAIT: begin
                if (bus.s) state_next = DECODE;
            end
            DECODE: begin
                case (opkey)
                    5'b110_10:                      state_next = WRITE_IMM;
                    5'b110_00, 5'b101_11:           state_next = GET_B;
                    5'b101_00, 5'b101_01, 5'b101_10: state_next = GET_A;
                    default:                        state_next = WAIT;
                endcase
            end
            WRITE_IMM: state_next = WAIT;
            GET_A:     state_next = GET_B;
            GET_B:     state_next = ALU;
            ALU: begin
                if (opkey == 5'b101_01) state_next = WAIT;
                else                    state_next = WRITE_REG;
            end
            WRITE_REG: state_next = WAIT;
            default:   state_next = WAIT;
        endcase
    end

    // Moore control word: everything idles at 0 except what the state drives.
    always_comb begin
        bus.w        = 1'b0;
        bus.done     = 1'b0;
        bus.writenum = 3'd0;
        bus.readnum  = 3'd0;
        bus.write    = 1'b0;
        bus.vsel     = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.ALUop    = 2'b00;
        bus.shift    = 2'b00;
        case (state)
            WAIT: bus.w = 1'b1;
            WRITE_IMM: begin
                bus.vsel     = 1'b1;
                bus.write    = 1'b1;
                bus.writenum = rn;
                bus.done     = 1'b1;
            end
            GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
            end
            GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
            end
            ALU: begin
                bus.shift = sh;
                if (opkey == 5'b110_00) begin
                    // MOV reg: A side forced to zero, ADD passes shifted B through.
                    bus.asel  = 1'b1;
                    bus.ALUop = 2'b00;
                    bus.loadc = 1'b1;
                end else if (opkey == 5'b101_01) begin
                    // CMP: only the status register is updated.
                    bus.ALUop = 2'b01;
                    bus.loads = 1'b1;
                    bus.done  = 1'b1;
                end else begin
                    bus.ALUop = op;
                    bus.loadc = 1'b1;
                end
            end
            WRITE_REG: begin
                bus.write    = 1'b1;
                bus.writenum = rd;
                bus.done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_datapath_controller.sv
// Directed self-checking bench for datapath_controller.
// Each cycle's full control word is compared against a hand-built expectation.
module tb_datapath_controller;

    logic clk;
    logic reset_n;

    datapath_controller_if #(.IW(16)) bus ();

    datapath_controller #(.IW(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Strobe bit masks within the 10-bit strobe field of a control word.
    localparam logic [9:0] W   = 10'b10_0000_0000;
    localparam logic [9:0] WR  = 10'b01_0000_0000;
    localparam logic [9:0] VS  = 10'b00_1000_0000;
    localparam logic [9:0] AS  = 10'b00_0100_0000;
    localparam logic [9:0] BS  = 10'b00_0010_0000;
    localparam logic [9:0] LA  = 10'b00_0001_0000;
    localparam logic [9:0] LB  = 10'b00_0000_1000;
    localparam logic [9:0] LC  = 10'b00_0000_0100;
    localparam logic [9:0] LS  = 10'b00_0000_0010;
    localparam logic [9:0] DN  = 10'b00_0000_0001;

    function automatic logic [19:0] cw(input logic [9:0] strobes, input logic [1:0] aluop,
                                       input logic [1:0] sh, input logic [2:0] rdn,
                                       input logic [2:0] wrn);
        return {strobes, aluop, sh, rdn, wrn};
    endfunction

    function automatic logic [19:0] dut_cw();
        return {bus.w, bus.write, bus.vsel, bus.asel, bus.bsel, bus.loada, bus.loadb,
                bus.loadc, bus.loads, bus.done, bus.ALUop, bus.shift, bus.readnum,
                bus.writenum};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_cw(input string tag, input logic [19:0] exp);
        check(tag, {12'd0, dut_cw()}, {12'd0, exp});
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction with load and s together (newly loaded IR is decoded).
    task automatic issue(input logic [15:0] instr);
        bus.in   = instr;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        step();
        bus.load = 1'b0;
        bus.s    = 1'b0;
    endtask

    initial begin
        clk      = 1'b0;
        reset_n  = 1'b0;
        bus.in   = '0;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        step();
        step();
        reset_n = 1'b1;

        // Reset state
        check_cw("reset_cw", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));
        check("reset_err", {31'd0, bus.err}, 32'd0);
        check("reset_imm", {16'd0, bus.datapath_in}, 32'h0000);

        // MOV R0,#-3
        issue(16'hD0FD);
        check_cw("movi_decode", cw('0, 2'b00, 2'b00, 3'd0, 3'd0));
        step();
        check_cw("movi_write", cw(VS | WR | DN, 2'b00, 2'b00, 3'd0, 3'd0));
        check("movi_imm", {16'd0, bus.datapath_in}, 32'h0000FFFD);
        step();
        check_cw("movi_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));

        // ADD R2,R1,R0 LSL#1 with busy-time load/s that must be ignored
        bus.in   = 16'hA148;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        check("add_ir_loaded", {16'd0, bus.datapath_in}, 32'h00000048);
        check_cw("add_still_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));
        bus.s = 1'b1;
        step();
        check_cw("add_decode", cw('0, 2'b00, 2'b00, 3'd0, 3'd0));
        bus.in   = 16'hD005;
        bus.load = 1'b1;
        step();
        check_cw("add_get_a", cw(LA, 2'b00, 2'b00, 3'd1, 3'd0));
        step();
        check_cw("add_get_b", cw(LB, 2'b00, 2'b00, 3'd0, 3'd0));
        bus.load = 1'b0;
        bus.s    = 1'b0;
        step();
        check_cw("add_alu", cw(LC, 2'b00, 2'b01, 3'd0, 3'd0));
        check("add_ir_kept", {16'd0, bus.datapath_in}, 32'h00000048);
        step();
        check_cw("add_write_reg", cw(WR | DN, 2'b00, 2'b00, 3'd0, 3'd2));
        step();
        check_cw("add_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));

        // CMP R1,R0
        issue(16'hA900);
        check_cw("cmp_decode", cw('0, 2'b00, 2'b00, 3'd0, 3'd0));
        step();
        check_cw("cmp_get_a", cw(LA, 2'b00, 2'b00, 3'd1, 3'd0));
        step();
        check_cw("cmp_get_b", cw(LB, 2'b00, 2'b00, 3'd0, 3'd0));
        step();
        check_cw("cmp_alu", cw(LS | DN, 2'b01, 2'b00, 3'd0, 3'd0));
        step();
        check_cw("cmp_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));

        // Illegal opcode, then a legal MOV R3,#5 still runs
        issue(16'hE000);
        check_cw("ill_decode", cw('0, 2'b00, 2'b00, 3'd0, 3'd0));
        check("ill_err_early", {31'd0, bus.err}, 32'd0);
        step();
        check_cw("ill_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));
        check("ill_err_set", {31'd0, bus.err}, 32'd1);
        issue(16'hD305);
        check_cw("mov3_decode", cw('0, 2'b00, 2'b00, 3'd0, 3'd0));
        step();
        check_cw("mov3_write", cw(VS | WR | DN, 2'b00, 2'b00, 3'd0, 3'd3));
        check("mov3_imm", {16'd0, bus.datapath_in}, 32'h00000005);
        check("mov3_err_sticky", {31'd0, bus.err}, 32'd1);
        step();
        check_cw("mov3_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));

        // MVN R5,R2 LSR#1
        issue(16'hB8B2);
        check_cw("mvn_decode", cw('0, 2'b00, 2'b00, 3'd0, 3'd0));
        step();
        check_cw("mvn_get_b", cw(LB, 2'b00, 2'b00, 3'd2, 3'd0));
        step();
        check_cw("mvn_alu", cw(LC, 2'b11, 2'b10, 3'd0, 3'd0));
        step();
        check_cw("mvn_write_reg", cw(WR | DN, 2'b00, 2'b00, 3'd0, 3'd5));
        step();
        check_cw("mvn_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));

        // MOV R7,R6 ASR#1
        issue(16'hC0FE);
        check_cw("movr_decode", cw('0, 2'b00, 2'b00, 3'd0, 3'd0));
        step();
        check_cw("movr_get_b", cw(LB, 2'b00, 2'b00, 3'd6, 3'd0));
        step();
        check_cw("movr_alu", cw(AS | LC, 2'b00, 2'b11, 3'd0, 3'd0));
        step();
        check_cw("movr_write_reg", cw(WR | DN, 2'b00, 2'b00, 3'd0, 3'd7));
        step();
        check_cw("movr_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));

        // s held high: the same IR restarts after completion
        bus.in   = 16'hD305;
        bus.load = 1'b1;
        bus.s    = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        check_cw("hold_write", cw(VS | WR | DN, 2'b00, 2'b00, 3'd0, 3'd3));
        step();
        check_cw("hold_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));
        step();
        check_cw("hold_restart", cw('0, 2'b00, 2'b00, 3'd0, 3'd0));
        bus.s = 1'b0;
        step();
        step();
        check_cw("hold_done_wait", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));

        // Reset during GET_B of an ADD (err is still 1 from the illegal op)
        issue(16'hA148);
        step();
        step();
        check_cw("rst_get_b", cw(LB, 2'b00, 2'b00, 3'd0, 3'd0));
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        check_cw("rst_cw", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));
        check("rst_err", {31'd0, bus.err}, 32'd0);
        check("rst_ir", {16'd0, bus.datapath_in}, 32'h0000);
        step();
        check_cw("rst_idle", cw(W, 2'b00, 2'b00, 3'd0, 3'd0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
